// File: rtl/axi4_burst_engine.sv
// axi4_burst_engine
// Single AXI4 full master that writes one INCR burst of an incrementing
// pattern (SEED, SEED+1, ...) to BASE_ADDR, or reads that burst back and
// counts data mismatches. Start pulses come from a control slave and are
// only honoured while idle; a simultaneous write+read start runs the write
// first and remembers the read as pending.
module axi4_burst_engine #(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int            BURST_LEN = 16,
  parameter logic [31:0]   SEED      = 32'h1000_0000
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start_write,
  input  logic          start_read,
  output logic          busy,
  output logic          wr_done,
  output logic          rd_done,
  output logic [1:0]    wr_resp,
  output logic [15:0]   rd_errors,
  output logic          rd_resp_err,
  output logic [AW-1:0] M_AXI_AWADDR,
  output logic [7:0]    M_AXI_AWLEN,
  output logic [2:0]    M_AXI_AWSIZE,
  output logic [1:0]    M_AXI_AWBURST,
  output logic          M_AXI_AWVALID,
  input  logic          M_AXI_AWREADY,
  output logic [31:0]   M_AXI_WDATA,
  output logic [3:0]    M_AXI_WSTRB,
  output logic          M_AXI_WLAST,
  output logic          M_AXI_WVALID,
  input  logic          M_AXI_WREADY,
  input  logic [1:0]    M_AXI_BRESP,
  input  logic          M_AXI_BVALID,
  output logic          M_AXI_BREADY,
  output logic [AW-1:0] M_AXI_ARADDR,
  output logic [7:0]    M_AXI_ARLEN,
  output logic [2:0]    M_AXI_ARSIZE,
  output logic [1:0]    M_AXI_ARBURST,
  output logic          M_AXI_ARVALID,
  input  logic          M_AXI_ARREADY,
  input  logic [31:0]   M_AXI_RDATA,
  input  logic [1:0]    M_AXI_RRESP,
  input  logic          M_AXI_RLAST,
  input  logic          M_AXI_RVALID,
  output logic          M_AXI_RREADY
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, WRITE, WRESP, READ} state_t;

  state_t state, next_state;

  logic       aw_valid, w_valid, ar_valid;
  logic       aw_done, w_done, pending;
  logic [7:0] w_beat, r_beat;
  logic       aw_hs, w_hs, ar_hs, r_hs;
  logic       w_last, r_last;
  logic       launch_write, launch_read, read_finish;

  assign w_last = (w_beat == LAST_BEAT);
  assign r_last = (r_beat == LAST_BEAT);
  assign aw_hs  = aw_valid & M_AXI_AWREADY;
  assign w_hs   = w_valid & M_AXI_WREADY;
  assign ar_hs  = ar_valid & M_AXI_ARREADY;
  assign r_hs   = (state == READ) & M_AXI_RVALID;

  // The burst geometry is fixed, so both address channels carry constants.
  assign M_AXI_AWADDR  = BASE_ADDR;
  assign M_AXI_AWLEN   = LAST_BEAT;
  assign M_AXI_AWSIZE  = 3'b010;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWVALID = aw_valid;
  assign M_AXI_WDATA   = SEED + 32'(w_beat);
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WLAST   = w_valid & w_last;
  assign M_AXI_WVALID  = w_valid;
  assign M_AXI_BREADY  = (state == WRESP);
  assign M_AXI_ARADDR  = BASE_ADDR;
  assign M_AXI_ARLEN   = LAST_BEAT;
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARVALID = ar_valid;
  assign M_AXI_RREADY  = (state == READ);
  assign busy          = (state != IDLE) | pending;

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic; a pending read outranks any new start pulse.
  always_comb begin
    next_state   = state;
    launch_write = 1'b0;
    launch_read  = 1'b0;
    read_finish  = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          launch_read = 1'b1;
          next_state  = READ;
        end else if (start_write) begin
          launch_write = 1'b1;
          next_state   = WRITE;
        end else if (start_read) begin
          launch_read = 1'b1;
          next_state  = READ;
        end
      end
      WRITE: begin
        if ((aw_done | aw_hs) & (w_done | (w_hs & w_last))) next_state = WRESP;
      end
      WRESP: begin
        if (M_AXI_BVALID) next_state = IDLE;
      end
      READ: begin
        if (r_hs & (M_AXI_RLAST | r_last)) begin
          read_finish = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Write address/data channels: AW and W start together and finish independently.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_valid <= 1'b0;
      w_valid  <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      w_beat   <= 8'd0;
    end else if (launch_write) begin
      aw_valid <= 1'b1;
      w_valid  <= 1'b1;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      w_beat   <= 8'd0;
    end else begin
      if (aw_hs) begin
        aw_valid <= 1'b0;
        aw_done  <= 1'b1;
      end
      if (w_hs) begin
        if (w_last) begin
          w_valid <= 1'b0;
          w_done  <= 1'b1;
        end else begin
          w_beat <= w_beat + 8'd1;
        end
      end
    end
  end

  // Remember a read that arrived together with a write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                         pending <= 1'b0;
    else if (launch_write & start_read)  pending <= 1'b1;
    else if (launch_read)                pending <= 1'b0;
  end

  // Read address channel, beat tracking and data/response checking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_valid    <= 1'b0;
      r_beat      <= 8'd0;
      rd_errors   <= 16'd0;
      rd_resp_err <= 1'b0;
    end else if (launch_read) begin
      ar_valid    <= 1'b1;
      r_beat      <= 8'd0;
      rd_errors   <= 16'd0;
      rd_resp_err <= 1'b0;
    end else if (state == READ) begin
      if (ar_hs | read_finish) ar_valid <= 1'b0;
      if (r_hs) begin
        if ((M_AXI_RDATA != SEED + 32'(r_beat)) && (rd_errors != 16'hFFFF))
          rd_errors <= rd_errors + 16'd1;
        if ((M_AXI_RRESP != 2'b00) || (M_AXI_RLAST != r_last))
          rd_resp_err <= 1'b1;
        r_beat <= r_beat + 8'd1;
      end
    end
  end

  // Completion pulses and the held write response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      wr_resp <= 2'b00;
    end else begin
      wr_done <= (state == WRESP) & M_AXI_BVALID;
      rd_done <= read_finish;
      if ((state == WRESP) && M_AXI_BVALID) wr_resp <= M_AXI_BRESP;
    end
  end

endmodule

// File: tb/tb_axi4_burst_engine.sv
// tb_axi4_burst_engine
// A behavioural AXI slave with configurable stalls and error injection
// drives the engine; expected data, counts and flags come from a simple
// per-transaction model of the burst rules.
module tb_axi4_burst_engine;

  localparam int          AW   = 32;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          LEN  = 4;
  localparam logic [31:0] SEED = 32'h0000_0010;

  logic        clk, resetn, start_write, start_read;
  logic        busy, wr_done, rd_done, rd_resp_err;
  logic [1:0]  wr_resp;
  logic [15:0] rd_errors;
  logic [31:0] awAddr, arAddr, wData, rData;
  logic [7:0]  awLen, arLen;
  logic [2:0]  awSize, arSize;
  logic [1:0]  awBurst, arBurst, bResp, rResp;
  logic [3:0]  wStrb;
  logic        awValid, awReady, wLast, wValid, wReady, bValid, bReady;
  logic        arValid, arReady, rLast, rValid, rReady;

  axi4_burst_engine #(.AW(AW), .BASE_ADDR(BASE), .BURST_LEN(LEN), .SEED(SEED)) dut (
    .clk(clk), .resetn(resetn), .start_write(start_write), .start_read(start_read),
    .busy(busy), .wr_done(wr_done), .rd_done(rd_done), .wr_resp(wr_resp),
    .rd_errors(rd_errors), .rd_resp_err(rd_resp_err),
    .M_AXI_AWADDR(awAddr), .M_AXI_AWLEN(awLen), .M_AXI_AWSIZE(awSize),
    .M_AXI_AWBURST(awBurst), .M_AXI_AWVALID(awValid), .M_AXI_AWREADY(awReady),
    .M_AXI_WDATA(wData), .M_AXI_WSTRB(wStrb), .M_AXI_WLAST(wLast),
    .M_AXI_WVALID(wValid), .M_AXI_WREADY(wReady),
    .M_AXI_BRESP(bResp), .M_AXI_BVALID(bValid), .M_AXI_BREADY(bReady),
    .M_AXI_ARADDR(arAddr), .M_AXI_ARLEN(arLen), .M_AXI_ARSIZE(arSize),
    .M_AXI_ARBURST(arBurst), .M_AXI_ARVALID(arValid), .M_AXI_ARREADY(arReady),
    .M_AXI_RDATA(rData), .M_AXI_RRESP(rResp), .M_AXI_RLAST(rLast),
    .M_AXI_RVALID(rValid), .M_AXI_RREADY(rReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Slave knobs, set by the main sequence while the engine is idle.
  int          readyPct = 100;
  int          stallLeft = 0;
  int          stallBeat = 0;
  bit          awAfterWlast = 0;
  logic [1:0]  bRespKnob = 2'b00;
  logic [3:0]  corruptMask = 4'b0000;
  int          rErrBeat = -1;
  int          earlyLast = -1;
  bit          noRlast = 0;

  // Slave bookkeeping and captured observations.
  bit          awSeen, bHsPred, arPred, arSeen, rHsPred, rEnd, prevWPend, prevWLast;
  int          wCount, rBeat;
  logic [31:0] prevWData;
  logic [31:0] wQ[$];
  int          stableErrs = 0, wlastErrs = 0, bEarly = 0, awCount = 0, arCount = 0, rBeats = 0;
  logic [31:0] capAwAddr, capArAddr;
  logic [7:0]  capAwLen, capArLen;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural slave: decides READYs/VALIDs on the falling edge and records
  // every handshake that will complete at the next rising edge.
  always @(negedge clk) begin
    if (!resetn) begin
      awReady = 0; wReady = 0; bValid = 0; bResp = 0; arReady = 0;
      rValid = 0; rLast = 0; rData = 0; rResp = 0;
      awSeen = 0; bHsPred = 0; arPred = 0; arSeen = 0; rHsPred = 0; rEnd = 0;
      prevWPend = 0; wCount = 0; rBeat = 0;
    end else begin
      if (bHsPred) begin
        bValid = 0; bHsPred = 0; awSeen = 0; wCount = 0;
      end
      if (bReady && !(awSeen && wCount == LEN)) bEarly++;
      if (prevWPend && !(wValid && wData == prevWData && wLast == prevWLast)) stableErrs++;
      awReady = awAfterWlast ? (wCount == LEN) : ($urandom_range(99) < readyPct);
      if (stallLeft > 0 && wValid && wCount == stallBeat) begin
        wReady = 0;
        stallLeft--;
      end else begin
        wReady = ($urandom_range(99) < readyPct);
      end
      if (awValid && awReady) begin
        awSeen = 1; awCount++; capAwAddr = awAddr; capAwLen = awLen;
      end
      if (wValid && wReady) begin
        wQ.push_back(wData);
        if (wLast !== (wCount == LEN - 1)) wlastErrs++;
        wCount++;
      end
      prevWPend = wValid && !wReady;
      prevWData = wData;
      prevWLast = wLast;
      if (!bValid && awSeen && wCount == LEN) begin
        bValid = 1; bResp = bRespKnob;
      end
      if (bValid && bReady) bHsPred = 1;

      if (rHsPred) begin
        rHsPred = 0;
        if (rEnd) begin
          arSeen = 0; rBeat = 0; rValid = 0; rLast = 0;
        end else begin
          rBeat++;
        end
      end
      if (arPred) begin
        arPred = 0; arSeen = 1;
      end
      arReady = ($urandom_range(99) < readyPct);
      if (arValid && arReady) begin
        arPred = 1; arCount++; capArAddr = arAddr; capArLen = arLen;
      end
      if (arSeen) begin
        rValid = ($urandom_range(99) < readyPct);
        rData  = corruptMask[rBeat] ? 32'h0000_DEAD : SEED + 32'(rBeat);
        rResp  = (rBeat == rErrBeat) ? 2'b10 : 2'b00;
        rLast  = noRlast ? 1'b0 : (rBeat == ((earlyLast >= 0) ? earlyLast : LEN - 1));
        if (rValid && rReady) begin
          rHsPred = 1; rBeats++;
          rEnd = rLast || (rBeat == LEN - 1);
        end
      end else begin
        rValid = 0;
      end
    end
  end

  task automatic setKnobs(input int pct);
    readyPct = pct; stallLeft = 0; stallBeat = 0; awAfterWlast = 0; bRespKnob = 2'b00;
    corruptMask = 4'b0000; rErrBeat = -1; earlyLast = -1; noRlast = 0;
    wQ.delete(); rBeats = 0; stableErrs = 0; wlastErrs = 0; bEarly = 0; awCount = 0; arCount = 0;
  endtask

  // Pulses the requested starts and follows the engine until it is idle.
  task automatic applyStimulus(input bit sw, input bit sr, input bit lateRead,
                               output int wrAt, output int rdAt, output int arAt,
                               output int wrCnt, output int rdCnt, output bit busyDrop);
    bit ended = 0;
    wrAt = -1; rdAt = -1; arAt = -1; wrCnt = 0; rdCnt = 0; busyDrop = 0;
    start_write = sw; start_read = sr;
    for (int k = 1; k <= 400 && !ended; k++) begin
      @(negedge clk);
      start_write = 0; start_read = 0;
      if (wr_done) begin wrCnt++; if (wrAt < 0) wrAt = k; end
      if (rd_done) begin rdCnt++; if (rdAt < 0) rdAt = k; end
      if (arValid && arAt < 0) arAt = k;
      if (lateRead && arAt >= 0 && k == arAt + 1) start_read = 1;
      if (!busy) begin
        ended = 1;
        if (sr && rdCnt == 0) busyDrop = 1;
      end
    end
    start_read = 0;
    checkOutput("idle_reached", ended, 1);
    #1;
  endtask

  task automatic checkWriteData(input string tag);
    checkOutput({tag, "_beats"}, wQ.size(), LEN);
    for (int i = 0; i < LEN && i < wQ.size(); i++)
      checkOutput({tag, "_wdata"}, wQ[i], SEED + 32'(i));
    checkOutput({tag, "_wlast"}, wlastErrs, 0);
  endtask

  int  wrAt, rdAt, arAt, wrCnt, rdCnt, op, endBeat, expErr;
  bit  busyDrop, found, expRespErr, stayIdle;

  initial begin
    start_write = 0; start_read = 0; resetn = 0;
    setKnobs(100);
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valids", {awValid, wValid, arValid, bReady, rReady}, 0);
    checkOutput("rst_status", {wr_done, rd_done, wr_resp, rd_resp_err}, 0);
    checkOutput("rst_rd_errors", rd_errors, 0);
    checkOutput("aw_fields", {awLen, 1'b0, awSize, 2'b00, awBurst, wStrb}, {8'd3, 1'b0, 3'b010, 2'b00, 2'b01, 4'hF});
    checkOutput("ar_fields", {arLen, 1'b0, arSize, 2'b00, arBurst}, {8'd3, 1'b0, 3'b010, 2'b00, 2'b01});
    #2 resetn = 1;
    @(negedge clk); #1;

    $display("[TB] basic write with latency");
    applyStimulus(1, 0, 0, wrAt, rdAt, arAt, wrCnt, rdCnt, busyDrop);
    checkOutput("lat_wr_done_cycle", wrAt, 6);
    checkOutput("lat_wr_done_count", wrCnt, 1);
    checkOutput("lat_wr_resp", wr_resp, 0);
    checkOutput("lat_awaddr", capAwAddr, BASE);
    checkWriteData("lat");

    $display("[TB] stalled write, late AW");
    setKnobs(100);
    stallBeat = 2; stallLeft = 3; awAfterWlast = 1; bRespKnob = 2'b01;
    applyStimulus(1, 0, 0, wrAt, rdAt, arAt, wrCnt, rdCnt, busyDrop);
    checkOutput("stall_stable", stableErrs, 0);
    checkOutput("stall_b_early", bEarly, 0);
    checkOutput("stall_wr_done_count", wrCnt, 1);
    checkOutput("stall_wr_resp", wr_resp, 1);
    checkWriteData("stall");

    $display("[TB] read with one bad beat");
    setKnobs(100);
    corruptMask = 4'b0010;
    applyStimulus(0, 1, 0, wrAt, rdAt, arAt, wrCnt, rdCnt, busyDrop);
    checkOutput("bad_rd_errors", rd_errors, 1);
    checkOutput("bad_rd_resp_err", rd_resp_err, 0);
    checkOutput("bad_rd_done_count", rdCnt, 1);
    checkOutput("bad_araddr", capArAddr, BASE);

    $display("[TB] simultaneous write and read");
    setKnobs(100);
    applyStimulus(1, 1, 1, wrAt, rdAt, arAt, wrCnt, rdCnt, busyDrop);
    checkOutput("both_wr_count", wrCnt, 1);
    checkOutput("both_rd_count", rdCnt, 1);
    checkOutput("both_ar_after_wr", arAt, wrAt + 1);
    checkOutput("both_busy_drop", busyDrop, 0);
    checkOutput("both_rd_errors", rd_errors, 0);
    stayIdle = 1;
    repeat (4) begin
      @(negedge clk);
      if (busy || arValid || awValid) stayIdle = 0;
    end
    checkOutput("both_late_read_ignored", stayIdle, 1);
    checkOutput("both_ar_count", arCount, 1);
    #1;

    $display("[TB] early RLAST");
    setKnobs(100);
    earlyLast = 2;
    applyStimulus(0, 1, 0, wrAt, rdAt, arAt, wrCnt, rdCnt, busyDrop);
    checkOutput("early_resp_err", rd_resp_err, 1);
    checkOutput("early_beats", rBeats, 3);
    checkOutput("early_rd_count", rdCnt, 1);

    $display("[TB] RRESP error");
    setKnobs(100);
    rErrBeat = 1;
    applyStimulus(0, 1, 0, wrAt, rdAt, arAt, wrCnt, rdCnt, busyDrop);
    checkOutput("rresp_resp_err", rd_resp_err, 1);
    checkOutput("rresp_rd_errors", rd_errors, 0);
    checkOutput("rresp_beats", rBeats, LEN);

    $display("[TB] reset during write");
    setKnobs(100);
    stallBeat = 2; stallLeft = 6;
    start_write = 1;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      start_write = 0;
      if (wValid && wData == SEED + 32'd2) found = 1;
    end
    checkOutput("rstw_reached_beat2", found, 1);
    #2 resetn = 0;
    #1;
    checkOutput("rstw_valids_low", {awValid, wValid, arValid, bReady, rReady}, 0);
    @(negedge clk);
    #2 resetn = 1;
    @(negedge clk);
    checkOutput("rstw_busy", busy, 0);
    #1;
    setKnobs(100);
    applyStimulus(1, 0, 0, wrAt, rdAt, arAt, wrCnt, rdCnt, busyDrop);
    checkOutput("rstw_wr_count", wrCnt, 1);
    checkWriteData("rstw");

    $display("[TB] randomized transactions");
    for (int it = 0; it < 20; it++) begin
      setKnobs($urandom_range(40, 100));
      op = $urandom_range(2);
      bRespKnob = 2'($urandom_range(3));
      corruptMask = 4'($urandom_range(15));
      rErrBeat = ($urandom_range(1) == 1) ? $urandom_range(LEN - 1) : -1;
      earlyLast = ($urandom_range(3) == 0) ? $urandom_range(LEN - 2) : -1;
      noRlast = (earlyLast < 0) && ($urandom_range(7) == 0);
      applyStimulus(op != 1, op != 0, 0, wrAt, rdAt, arAt, wrCnt, rdCnt, busyDrop);
      if (op != 1) begin
        checkOutput("rnd_wr_count", wrCnt, 1);
        checkOutput("rnd_wr_resp", wr_resp, bRespKnob);
        checkWriteData("rnd");
      end
      if (op != 0) begin
        endBeat = (earlyLast >= 0) ? earlyLast : LEN - 1;
        expErr = 0;
        for (int i = 0; i <= endBeat; i++) if (corruptMask[i]) expErr++;
        expRespErr = (earlyLast >= 0) || noRlast || (rErrBeat >= 0 && rErrBeat <= endBeat);
        checkOutput("rnd_rd_count", rdCnt, 1);
        checkOutput("rnd_rd_errors", rd_errors, expErr);
        checkOutput("rnd_rd_resp_err", rd_resp_err, expRespErr);
        checkOutput("rnd_rd_beats", rBeats, endBeat + 1);
      end
      if (op == 2) checkOutput("rnd_order", arAt > wrAt, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4_burst_engine.md
Name: axi4_burst_engine

Overview:
Downstream consumer of the AXI4-Lite control slave's start_write/start_read pulses. Drives a single AXI4 full master that writes one INCR burst of an incrementing pattern to a fixed address, or reads that burst back and checks it. Reports completion pulses, the write response and read error counts for status readback.

Parameters:
AW, 32, AXI address width.
BASE_ADDR, 0, burst start address (4-byte aligned, burst must not cross 4 KB).
BURST_LEN, 16, beats per burst (1..256).
SEED, 32'h1000_0000, data of beat 0; beat i carries SEED+i (mod 2^32).

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start_write  in  1  1-cycle pulse: launch write burst
start_read  in  1  1-cycle pulse: launch read burst
busy  out  1  high while any burst is active or pending
wr_done  out  1  1-cycle pulse when B handshake completes
rd_done  out  1  1-cycle pulse when the RLAST beat is accepted
wr_resp  out  2  BRESP of the last write, held until the next one
rd_errors  out  16  data mismatches in the last read, saturating
rd_resp_err  out  1  any RRESP!=0 or RLAST misplacement in the last read
M_AXI_AWADDR  out  AW  = BASE_ADDR
M_AXI_AWLEN  out  8  = BURST_LEN-1
M_AXI_AWSIZE  out  3  = 3'b010
M_AXI_AWBURST  out  2  = 2'b01 (INCR)
M_AXI_AWVALID  out  1  address valid
M_AXI_AWREADY  in  1  address ready
M_AXI_WDATA  out  32  SEED+beat
M_AXI_WSTRB  out  4  = 4'hF
M_AXI_WLAST  out  1  high on beat BURST_LEN-1
M_AXI_WVALID  out  1  data valid
M_AXI_WREADY  in  1  data ready
M_AXI_BRESP  in  2  write response
M_AXI_BVALID  in  1  response valid
M_AXI_BREADY  out  1  response ready
M_AXI_ARADDR/ARLEN/ARSIZE/ARBURST  out  AW/8/3/2  same values as AW channel
M_AXI_ARVALID  out  1  read address valid
M_AXI_ARREADY  in  1  read address ready
M_AXI_RDATA  in  32  read data
M_AXI_RRESP  in  2  read response
M_AXI_RLAST  in  1  last read beat
M_AXI_RVALID  in  1  read data valid
M_AXI_RREADY  out  1  read data ready

Behaviour:
- Reset (async, resetn=0): all VALID/READY, busy, wr_done, rd_done, rd_resp_err=0; wr_resp=0; rd_errors=0; FSM to IDLE; beat counters and pending flag cleared. Any in-flight burst is abandoned.
- FSM states: IDLE, WRITE, WRESP, READ. Start pulses are sampled only in IDLE; a pulse in any other state is ignored.
- IDLE + start_write: next cycle assert AWVALID and WVALID together (W does not wait for AW); enter WRITE. AWVALID drops after the AW handshake. WDATA advances only on a W handshake, and VALID/data hold stable until READY.
- WRITE -> WRESP after the WLAST handshake and the AW handshake have both occurred, in either order. In WRESP, BREADY=1; on BVALID, latch wr_resp, pulse wr_done, go to IDLE.
- IDLE + start_read: clear rd_errors and rd_resp_err, assert ARVALID, enter READ. RREADY=1 throughout READ, including before the AR handshake.
- Each R beat i: if RDATA!=SEED+i, rd_errors+1 (saturating at 16'hFFFF). rd_resp_err is set by RRESP!=0, by RLAST on beat i<BURST_LEN-1, or by RLAST absent on the final beat.
- READ -> IDLE and rd_done pulse on the first of RLAST or beat BURST_LEN-1.
- start_write and start_read in the same IDLE cycle: the write runs first and the read is latched as pending. The read launches in the cycle after wr_done.
- busy = (state!=IDLE) || pending.
- Minimum latency: start_write to wr_done is BURST_LEN+2 cycles with all READYs high and BVALID returned the cycle after WLAST.

Test Plan:
- BURST_LEN=4, SEED=0x10, AW/W/B always ready: start_write -> WDATA 0x10,0x11,0x12,0x13; WLAST on the 4th beat; wr_done at cycle 6; wr_resp=0.
- Slave drops WREADY on beat 2 for 3 cycles and AWREADY arrives after WLAST -> data held stable; WRESP entered only after both handshakes; wr_done once.
- Read returning SEED+i except beat 1 = 0xDEAD, RRESP=0 -> rd_errors=1, rd_resp_err=0, one rd_done pulse.
- start_write and start_read in the same cycle -> write completes; ARVALID rises the cycle after wr_done; busy stays high continuously; start_read pulse during READ is ignored.
- RLAST on beat 2 of 4, or RRESP=2 on any beat -> rd_resp_err=1 and rd_done on that beat.
- resetn low mid-write (beat 2) -> all VALIDs low immediately (async); after release, busy=0 and a new start_write produces a clean full burst.
